// File: rtl/mul_control_rv32m.sv
// -----------------------------------------------------------------------------
// mul_control_rv32m
//
// Control stage in front of an unsigned RV32M multiplier datapath.
// Accepts one multiply request at a time and decodes funct3 into
// MUL / MULH / MULHSU / MULHU. Signed operands are turned into magnitudes
// for the multiplier. The product's sign is restored afterwards, then the
// low or high half is selected. The result is held under a valid/ready
// handshake toward writeback.
//
// Compile-time option:
//   MUL_ZERO_BYPASS_EN - when defined, a request with a zero operand skips
//                        the multiplier and responds with 0 one cycle after
//                        acceptance. When undefined, zero operands use the
//                        normal multiplier path.
//
// Parameters:
//   W           operand / result width (product is 2*W)
//
// Ports:
//   CLK         clock, all state changes on the rising edge
//   RESET       asynchronous, active-low reset
//   req_valid   request present            req_ready   can accept (IDLE only)
//   funct3      operation select           rs1, rs2    operands
//   rd_in       destination tag
//   rsp_valid   result available           rsp_ready   consumer accepts
//   rsp_result  selected product half      rsp_rd      tag of the response
//   rsp_err     illegal funct3 (1xx)
//   A, B        unsigned magnitudes to the multiplier
//   start       one-cycle launch pulse to the multiplier
//   done        multiplier completion, S is valid in the same cycle
//   S           unsigned 2*W product
// -----------------------------------------------------------------------------
module mul_control_rv32m #(
    parameter int W = 32
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [2:0]     funct3,
    input  logic [W-1:0]   rs1,
    input  logic [W-1:0]   rs2,
    input  logic [4:0]     rd_in,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_result,
    output logic [4:0]     rsp_rd,
    output logic           rsp_err,
    output logic [W-1:0]   A,
    output logic [W-1:0]   B,
    output logic           start,
    input  logic           done,
    input  logic [2*W-1:0] S
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_FIX,
        ST_RESP
    } state_t;

    state_t           state_reg;
    logic             req_ready_reg;
    logic             rsp_valid_reg;
    logic [W-1:0]     rsp_result_reg;
    logic [4:0]       rsp_rd_reg;
    logic             rsp_err_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic             start_reg;
    logic             is_mul_reg;    // low half selected (MUL)
    logic             negate_reg;    // product must be two's-complement negated
    logic [2*W-1:0]   prod_reg;

    // ------------------------------------------------------------------
    // Request decode (only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic             is_legal;
    logic             zero_op;
    logic [1:0]       op_signed;
    logic [1:0][W-1:0] op_in;
    logic [1:0][W-1:0] op_mag;
    logic [1:0]       op_neg;

    assign is_legal     = ~funct3[2];
    // MULH: both signed; MULHSU: rs1 signed only; MUL/MULHU: both unsigned.
    assign op_signed[0] = (funct3 == 3'b001) || (funct3 == 3'b010);
    assign op_signed[1] = (funct3 == 3'b001);
    assign op_in[0]     = rs1;
    assign op_in[1]     = rs2;
    assign zero_op      = (rs1 == '0) || (rs2 == '0);

    // Magnitude of each operand. The most negative value negates to itself,
    // whose unsigned reading is exactly 2^(W-1), so no extra bit is needed.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mag
            assign op_neg[gi] = op_signed[gi] & op_in[gi][W-1];
            assign op_mag[gi] = op_neg[gi] ? -op_in[gi] : op_in[gi];
        end
    endgenerate

    // Sign correction of the captured unsigned product
    logic [2*W-1:0] prod_fixed;
    assign prod_fixed = negate_reg ? -prod_reg : prod_reg;

    // ------------------------------------------------------------------
    // Control FSM, all outputs registered
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg      <= ST_IDLE;
            req_ready_reg  <= 1'b1;
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_rd_reg     <= '0;
            rsp_err_reg    <= 1'b0;
            a_reg          <= '0;
            b_reg          <= '0;
            start_reg      <= 1'b0;
            is_mul_reg     <= 1'b0;
            negate_reg     <= 1'b0;
            prod_reg       <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        is_mul_reg    <= (funct3[1:0] == 2'b00);
                        negate_reg    <= op_neg[0] ^ op_neg[1];
                        rsp_rd_reg    <= rd_in;
                        a_reg         <= op_mag[0];
                        b_reg         <= op_mag[1];
                        req_ready_reg <= 1'b0;
                        if (!is_legal) begin
                            rsp_result_reg <= '0;
                            rsp_err_reg    <= 1'b1;
                            rsp_valid_reg  <= 1'b1;
                            state_reg      <= ST_RESP;
                        end
`ifdef MUL_ZERO_BYPASS_EN
                        else if (zero_op) begin
                            rsp_result_reg <= '0;
                            rsp_err_reg    <= 1'b0;
                            rsp_valid_reg  <= 1'b1;
                            state_reg      <= ST_RESP;
                        end
`endif
                        else begin
                            rsp_err_reg <= 1'b0;
                            start_reg   <= 1'b1;
                            state_reg   <= ST_LAUNCH;
                        end
                    end
                end

                ST_LAUNCH: begin
                    // done during the start cycle is not a completion
                    start_reg <= 1'b0;
                    state_reg <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (done) begin
                        prod_reg  <= S;
                        state_reg <= ST_FIX;
                    end
                end

                ST_FIX: begin
                    rsp_result_reg <= is_mul_reg ? prod_fixed[W-1:0]
                                                 : prod_fixed[2*W-1:W];
                    rsp_valid_reg  <= 1'b1;
                    state_reg      <= ST_RESP;
                end

                ST_RESP: begin
                    // req_ready rises only after the handshake cycle
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg     <= ST_IDLE;
                    req_ready_reg <= 1'b1;
                    rsp_valid_reg <= 1'b0;
                    start_reg     <= 1'b0;
                end
            endcase
        end
    end

`ifndef MUL_ZERO_BYPASS_EN
    // Zero detection is only consumed by the bypass path
    logic unused_zero_op;
    assign unused_zero_op = zero_op;
`endif

    assign req_ready  = req_ready_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_rd     = rsp_rd_reg;
    assign rsp_err    = rsp_err_reg;
    assign A          = a_reg;
    assign B          = b_reg;
    assign start      = start_reg;

endmodule

// File: tb/tb_mul_control_rv32m.sv
// -----------------------------------------------------------------------------
// Testbench for mul_control_rv32m: multiplier model, scoreboard queue filled
// by the driver, independent monitor that checks every response.
// -----------------------------------------------------------------------------
module tb_mul_control_rv32m;

    localparam int W = 32;

    logic           CLK = 1'b0;
    logic           RESET = 1'b0;
    logic           req_valid, req_ready;
    logic [2:0]     funct3;
    logic [W-1:0]   rs1, rs2;
    logic [4:0]     rd_in;
    logic           rsp_valid, rsp_ready;
    logic [W-1:0]   rsp_result;
    logic [4:0]     rsp_rd;
    logic           rsp_err;
    logic [W-1:0]   A, B;
    logic           start;
    logic           done;
    logic [2*W-1:0] S;

    mul_control_rv32m #(.W(W)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .rd_in(rd_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
        .A(A), .B(B), .start(start), .done(done), .S(S)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        err;
        int          rise;     // cyc value at the negedge where rsp_valid rises
        int          starts;   // total start pulses expected by handshake time
    } exp_t;

    exp_t sb_q[$];
    int   exp_starts = 0;
    int   start_cnt  = 0;
    int   n_lat      = 4;
    int   fixed_hold = 0;      // -1: random backpressure

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: RISC-V M semantics computed with 64-bit arithmetic.
    function automatic void ref_model(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] res,
                                      output logic err);
        longint      p;
        logic [63:0] u;
        err = 1'b0;
        res = '0;
        case (f)
            3'b000: begin u = {32'b0, a} * {32'b0, b}; res = u[31:0]; end
            3'b001: begin p = longint'($signed(a)) * longint'($signed(b)); u = p; res = u[63:32]; end
            3'b010: begin p = longint'($signed(a)) * longint'({32'b0, b}); u = p; res = u[63:32]; end
            3'b011: begin u = {32'b0, a} * {32'b0, b}; res = u[63:32]; end
            default: err = 1'b1;
        endcase
    endfunction

    // Multiplier model: done exactly n_lat cycles after the start cycle.
    int mcnt = 0;
    initial begin
        done = 1'b0;
        S    = '0;
        forever begin
            @(negedge CLK);
            done = 1'b0;
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    done = 1'b1;
                    S    = {32'b0, A} * {32'b0, B};
                end
            end
            if (start) begin
                start_cnt++;
                mcnt = n_lat;
            end
        end
    end

    // Writeback consumer with configurable backpressure
    initial begin
        int hold, hcnt;
        hold = 0;
        hcnt = 0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge CLK);
            if (!rsp_valid) begin
                hcnt = 0;
                rsp_ready = 1'b0;
            end else begin
                if (hcnt == 0)
                    hold = (fixed_hold >= 0) ? fixed_hold : int'($urandom_range(0, 3));
                rsp_ready = (hcnt >= hold);
                hcnt++;
            end
        end
    end

    // Monitor: compares every response against the scoreboard head.
    initial begin
        logic        prev_valid, prev_hs;
        logic [37:0] held;
        exp_t        cur;
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        held       = '0;
        forever begin
            @(negedge CLK);
            #1;
            if (!RESET) begin
                prev_valid = 1'b0;
                prev_hs    = 1'b0;
                continue;
            end
            if (prev_hs) check("req_ready_after_handshake", req_ready, 1'b1);
            prev_hs = 1'b0;
            if (rsp_valid) begin
                if (!prev_valid) begin
                    check("rsp_expected", sb_q.size() > 0, 1'b1);
                    if (sb_q.size() > 0) check("rsp_valid_cycle", cyc, sb_q[0].rise);
                    held = {rsp_result, rsp_rd, rsp_err};
                end else begin
                    check("rsp_held_stable", {rsp_result, rsp_rd, rsp_err}, held);
                    check("req_ready_low_in_resp", req_ready, 1'b0);
                end
                if (rsp_ready) begin
                    if (sb_q.size() > 0) begin
                        cur = sb_q.pop_front();
                        $display("[TB] rsp rd=%0d result=%08h err=%0d (expected %08h err=%0d)",
                                 rsp_rd, rsp_result, rsp_err, cur.result, cur.err);
                        check("rsp_result", rsp_result, cur.result);
                        check("rsp_rd", rsp_rd, cur.rd);
                        check("rsp_err", rsp_err, cur.err);
                        check("start_pulses", start_cnt, cur.starts);
                    end
                    prev_hs = 1'b1;
                end
            end
            prev_valid = rsp_valid;
        end
    end

    // Driver: call at a negedge; returns at the negedge of cycle 1.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int lat);
        exp_t e;
        int   t;
        logic short_path;
        req_valid = 1'b1;
        funct3 = f; rs1 = a; rs2 = b; rd_in = rd;
        t = 0;
        while (!req_ready && t < 300) begin
            @(negedge CLK);
            t++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 1'b0, 1'b1);
            req_valid = 1'b0;
            return;
        end
        n_lat = lat;
        ref_model(f, a, b, e.result, e.err);
        e.rd = rd;
        short_path = e.err;
`ifdef MUL_ZERO_BYPASS_EN
        if (a == 0 || b == 0) short_path = 1'b1;
`endif
        e.rise = cyc + (short_path ? 1 : 3 + lat);
        if (!short_path) exp_starts++;
        e.starts = exp_starts;
        sb_q.push_back(e);
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || !req_ready) && t < 300) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 300) check("drain_timeout", 1'b0, 1'b1);
        @(negedge CLK);
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int vcnt;
        req_valid = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0; rd_in = '0;
        repeat (2) @(negedge CLK);
        check("reset_outputs", {req_ready, rsp_valid, rsp_result, rsp_rd, rsp_err, start},
              {1'b1, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0});
        check("reset_ab", {A, B}, 64'h0);
        RESET = 1'b1;
        @(negedge CLK);

        // Directed cases
        fixed_hold = 0;
        issue(3'b000, 32'd7, 32'd6, 5'd5, 4);                 drain();
        issue(3'b001, 32'hFFFF_FFFF, 32'h2, 5'd1, 4);         drain();
        issue(3'b011, 32'hFFFF_FFFF, 32'h2, 5'd2, 4);         drain();
        issue(3'b000, 32'hFFFF_FFFF, 32'h2, 5'd3, 4);         drain();
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 4); drain();
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 4); drain();

        // Backpressure: ready held low for 5 cycles
        fixed_hold = 5;
        issue(3'b001, 32'hFFFF_FFF9, 32'd3, 5'd7, 4);         drain();
        fixed_hold = 0;

        // Illegal funct3
        issue(3'b100, 32'd11, 32'd13, 5'd8, 4);               drain();

        // Reset in WAIT, stray done afterwards, request during reset ignored
        issue(3'b000, 32'd2, 32'd3, 5'd9, 4);   // returns in cycle 1
        @(negedge CLK);                          // cycle 2, WAIT
        @(negedge CLK);                          // cycle 3, WAIT
        RESET = 1'b0;
        req_valid = 1'b1; funct3 = 3'b000; rs1 = 32'd4; rs2 = 32'd4; rd_in = 5'd10;
        #1;
        check("reset_mid_outputs", {req_ready, rsp_valid, rsp_result, rsp_rd, rsp_err, start},
              {1'b1, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0});
        check("reset_mid_ab", {A, B}, 64'h0);
        sb_q.delete();
        @(negedge CLK);                          // cycle 4
        req_valid = 1'b0;
        RESET = 1'b1;                            // done arrives next cycle
        vcnt = 0;
        repeat (10) begin
            @(negedge CLK);
            if (rsp_valid) vcnt++;
        end
        check("no_rsp_after_reset", vcnt, 0);
        check("idle_after_reset", req_ready, 1'b1);
        issue(3'b000, 32'd3, 32'd5, 5'd11, 4);                drain();

        // Zero operand (bypassed when MUL_ZERO_BYPASS_EN is defined)
        issue(3'b011, 32'd0, 32'd9, 5'd12, 4);                drain();

        // Randomized traffic with random latency and backpressure
        fixed_hold = -1;
        for (int i = 0; i < 80; i++) begin
            logic [2:0] f;
            f = ($urandom_range(0, 4) == 4) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            issue(f, pick_op(), pick_op(), 5'($urandom_range(0, 31)), int'($urandom_range(1, 6)));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
